// File: rtl/apb_cfg_sequencer_if.sv
// APB top-level master port bundle: strobe, direction, one-hot select, address,
// write data out and read data back.
interface apb_cfg_sequencer_if #(
  parameter int ADDR_WIDTH  = 7,
  parameter int COEFF_WIDTH = 20,
  parameter int PDATA_WIDTH = 32,
  parameter int COMP        = 4
);
  logic                   MTRANS;
  logic                   MWRITE;
  logic [COMP-1:0]        MSELx;
  logic [ADDR_WIDTH-1:0]  MADDR;
  logic [COEFF_WIDTH-1:0] MWDATA;
  logic [PDATA_WIDTH-1:0] MRDATA;

  modport master (
    output MTRANS, MWRITE, MSELx, MADDR, MWDATA,
    input  MRDATA
  );

  modport slave (
    input  MTRANS, MWRITE, MSELx, MADDR, MWDATA,
    output MRDATA
  );
endinterface

// File: rtl/apb_cfg_sequencer.sv
// Burst command sequencer driving the APB master port: one command plus a write
// stream becomes back-to-back single transactions paced by a fixed gap.
module apb_cfg_sequencer #(
  parameter int ADDR_WIDTH  = 7,
  parameter int COEFF_WIDTH = 20,
  parameter int PDATA_WIDTH = 32,
  parameter int COMP        = 4,
  parameter int LEN_WIDTH   = 8,
  parameter int XFER_GAP    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  // cmd and wr are valid/ready: a transfer happens on a rising edge where both
  // valid and ready are high; ready depends only on state, never on valid.
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [$clog2(COMP)-1:0]       cmd_sel,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [LEN_WIDTH-1:0]          cmd_len,
  input  logic                          wr_valid,
  input  logic signed [COEFF_WIDTH-1:0] wr_data,
  output logic                          wr_ready,
  output logic                          rd_valid,
  output logic [PDATA_WIDTH-1:0]        rd_data,
  input  logic                          abort,
  apb_cfg_sequencer_if.master           apb,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          aborted,
  output logic [2:0]                    state_dbg
);
  localparam int GAP_WIDTH = $clog2(XFER_GAP);
  localparam int SUM_WIDTH = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;
  localparam logic [SUM_WIDTH-1:0] ADDR_SPAN = SUM_WIDTH'(1) << ADDR_WIDTH;
  localparam logic [GAP_WIDTH-1:0] GAP_LOAD  = GAP_WIDTH'(XFER_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_GAP    = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t                   state, state_nxt;
  logic [$clog2(COMP)-1:0]  sel_q;
  logic [ADDR_WIDTH-1:0]    cur_addr;
  logic [LEN_WIDTH-1:0]     rem_cnt;
  logic [GAP_WIDTH-1:0]     gap_cnt;
  logic                     dir_q;
  logic                     abort_q;
  logic                     mtrans_q, mwrite_q;
  logic [COMP-1:0]          msel_q;
  logic [ADDR_WIDTH-1:0]    maddr_q;
  logic [COEFF_WIDTH-1:0]   mwdata_q;
  logic [SUM_WIDTH-1:0]     cmd_end;
  logic                     cmd_bad, gap_last, last_word;

  // A burst may end exactly on the top address but never wrap past it.
  assign cmd_end   = SUM_WIDTH'(cmd_addr) + SUM_WIDTH'(cmd_len);
  assign cmd_bad   = (cmd_len == '0) || (cmd_end > ADDR_SPAN);
  assign gap_last  = (gap_cnt == '0);
  assign last_word = (rem_cnt == LEN_WIDTH'(1));

  assign cmd_ready  = (state == S_IDLE);
  assign wr_ready   = (state == S_FETCH);
  assign state_dbg  = state;
  assign apb.MTRANS = mtrans_q;
  assign apb.MWRITE = mwrite_q;
  assign apb.MSELx  = msel_q;
  assign apb.MADDR  = maddr_q;
  assign apb.MWDATA = mwdata_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cmd_valid && !cmd_bad) state_nxt = cmd_write ? S_FETCH : S_ISSUE;
      S_FETCH:  if (abort) state_nxt = S_FINISH;
                else if (wr_valid) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = S_GAP;
      S_GAP:    if (gap_last) begin
                  if (last_word || abort_q || abort) state_nxt = S_FINISH;
                  else state_nxt = dir_q ? S_FETCH : S_ISSUE;
                end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      sel_q    <= '0;
      cur_addr <= '0;
      rem_cnt  <= '0;
      gap_cnt  <= '0;
      dir_q    <= 1'b0;
      abort_q  <= 1'b0;
      mtrans_q <= 1'b0;
      mwrite_q <= 1'b0;
      msel_q   <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != S_IDLE);
      mtrans_q <= (state_nxt == S_ISSUE);
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      aborted  <= 1'b0;
      case (state)
        S_IDLE: if (cmd_valid) begin
          if (cmd_bad) begin
            err <= 1'b1;
          end else begin
            sel_q    <= cmd_sel;
            cur_addr <= cmd_addr;
            rem_cnt  <= cmd_len;
            dir_q    <= cmd_write;
            abort_q  <= 1'b0;
            if (!cmd_write) begin
              msel_q   <= COMP'(1) << cmd_sel;
              maddr_q  <= cmd_addr;
              mwrite_q <= 1'b0;
            end
          end
        end
        S_FETCH: begin
          if (abort) begin
            abort_q <= 1'b1;
          end else if (wr_valid) begin
            mwdata_q <= wr_data;
            msel_q   <= COMP'(1) << sel_q;
            maddr_q  <= cur_addr;
            mwrite_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          gap_cnt <= GAP_LOAD;
          if (abort) abort_q <= 1'b1;
        end
        S_GAP: begin
          if (abort) abort_q <= 1'b1;
          if (!gap_last) begin
            gap_cnt <= gap_cnt - GAP_WIDTH'(1);
          end else begin
            rem_cnt  <= rem_cnt - LEN_WIDTH'(1);
            cur_addr <= cur_addr + ADDR_WIDTH'(1);
            if (!dir_q) begin
              rd_data  <= apb.MRDATA;
              rd_valid <= 1'b1;
            end
            // Reads chain straight into the next strobe without a FETCH.
            if (state_nxt == S_ISSUE) maddr_q <= cur_addr + ADDR_WIDTH'(1);
          end
        end
        S_FINISH: begin
          if (abort_q) aborted <= 1'b1;
          else done <= 1'b1;
          msel_q  <= '0;
          abort_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
